// File: rtl/lane_pkg.sv
// Shared types for the lane packer: default geometry, lane/word/mask types, FSM states.
// No logic here; widths in the modules follow their own parameters.
// Types below are sized for the default geometry.
package lane_pkg;

  localparam int LANES_DEF  = 4;
  localparam int DATA_W_DEF = 8;

  typedef logic [DATA_W_DEF-1:0]                 lane_t;
  typedef logic [LANES_DEF-1:0][DATA_W_DEF-1:0]  word_t;
  typedef logic [LANES_DEF-1:0]                  mask_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/lane_packer_acc.sv
// Lane accumulator and write-lane counter; merged_* shows the accumulator with the incoming byte applied.
// Latency: writes land on the next clk edge; merged_* is combinational.
// Backpressure: none here, the caller gates wr_en with its own handshake.
module lane_packer_acc #(
  parameter int  LANES  = 4,
  parameter int  DATA_W = 8,
  localparam int CNT_W  = $clog2(LANES)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic                          wr_close,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [CNT_W-1:0]              lane_idx,
  output logic [LANES-1:0][DATA_W-1:0]  merged_word,
  output logic [LANES-1:0]              merged_mask
);

  logic [LANES-1:0][DATA_W-1:0] acc_word;
  logic [LANES-1:0]             acc_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_word <= '0;
      acc_mask <= '0;
      lane_idx <= '0;
    end else if (wr_en) begin
      // A closing byte goes straight to the output register, so the accumulator restarts empty.
      if (wr_close) begin
        acc_word <= '0;
        acc_mask <= '0;
        lane_idx <= '0;
      end else begin
        acc_word[lane_idx] <= wr_data;
        acc_mask[lane_idx] <= 1'b1;
        lane_idx           <= lane_idx + CNT_W'(1);
      end
    end
  end

  always_comb begin
    merged_word           = acc_word;
    merged_mask           = acc_mask;
    merged_word[lane_idx] = wr_data;
    merged_mask[lane_idx] = 1'b1;
  end

endmodule

// File: rtl/lane_packer.sv
// Packs a byte stream into LANES-lane words with a lane-valid mask, closing early on in_last.
// Latency: closing byte appears on out_* one cycle after its in_fire; one byte per cycle sustained.
// Backpressure: one output word held; in_ready drops only while a word is held and out_ready is low.
module lane_packer
  import lane_pkg::*;
#(
  parameter int  LANES  = LANES_DEF,
  parameter int  DATA_W = DATA_W_DEF,
  localparam int CNT_W  = $clog2(LANES)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES-1:0][DATA_W-1:0]  out_word,
  output logic [LANES-1:0]              out_mask
);

  state_e                       state, state_nxt;
  logic [CNT_W-1:0]             lane_idx;
  logic [LANES-1:0][DATA_W-1:0] merged_word;
  logic [LANES-1:0]             merged_mask;
  logic                         in_fire, out_fire, close_word;

  assign in_ready   = (state == FILL) | out_ready;
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign close_word = in_fire & ((lane_idx == CNT_W'(LANES-1)) | in_last);

  lane_packer_acc #(
    .LANES  (LANES),
    .DATA_W (DATA_W)
  ) u_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (in_fire),
    .wr_close    (close_word),
    .wr_data     (in_data),
    .lane_idx    (lane_idx),
    .merged_word (merged_word),
    .merged_mask (merged_mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  // A newly closed word takes priority: it replaces a word drained in the same cycle.
  always_comb begin
    state_nxt = state;
    if (close_word)    state_nxt = HOLD;
    else if (out_fire) state_nxt = FILL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_mask  <= '0;
    end else if (close_word) begin
      out_valid <= 1'b1;
      out_word  <= merged_word;
      out_mask  <= merged_mask;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lane_packer.sv
// Directed bench for lane_packer: hand-computed words and masks for full, partial,
// stalled, streaming, drain-with-last and mid-word reset cases.
module tb_lane_packer;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_last;
  logic [7:0]       in_data;
  logic             out_valid, out_ready;
  logic [3:0][7:0]  out_word;
  logic [3:0]       out_mask;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lane_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_mask  (out_mask)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte, take the clock edge, settle just after it.
  task automatic send(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;

    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_word",  64'(out_word),  64'd0);
    chk("rst_out_mask",  64'(out_mask),  64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Full word
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    chk("full_no_early_valid", 64'(out_valid), 64'd0);
    send(8'h44, 1'b0);
    chk("full_valid", 64'(out_valid), 64'd1);
    chk("full_word",  64'(out_word),  64'h44332211);
    chk("full_mask",  64'(out_mask),  64'hF);
    idle();
    chk("full_one_cycle", 64'(out_valid), 64'd0);

    // Partial word closed by in_last
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    chk("part_valid", 64'(out_valid), 64'd1);
    chk("part_word",  64'(out_word),  64'h0000BBAA);
    chk("part_mask",  64'(out_mask),  64'h3);
    idle();
    chk("part_drained", 64'(out_valid), 64'd0);

    // Backpressure
    out_ready = 1'b0;
    send(8'h04, 1'b0);
    send(8'h03, 1'b0);
    send(8'h02, 1'b0);
    send(8'h01, 1'b0);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_word",  64'(out_word),  64'h01020304);
      chk("bp_hold_mask",  64'(out_mask),  64'hF);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_on_drain", 64'(in_ready), 64'd1);
    idle();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Streaming 8 bytes with no bubble
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      in_last  = 1'b0;
      #1;
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      if (i == 3) begin
        chk("stream_w0_valid", 64'(out_valid), 64'd1);
        chk("stream_w0_word",  64'(out_word),  64'h03020100);
        chk("stream_w0_mask",  64'(out_mask),  64'hF);
      end
      if (i == 4) chk("stream_w0_drained", 64'(out_valid), 64'd0);
      if (i == 7) begin
        chk("stream_w1_valid", 64'(out_valid), 64'd1);
        chk("stream_w1_word",  64'(out_word),  64'h07060504);
      end
    end
    in_valid = 1'b0;
    idle();

    // Drain a held word while a single in_last byte closes the next one
    out_ready = 1'b0;
    send(8'h10, 1'b0);
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    send(8'h13, 1'b0);
    chk("dl_held", 64'(out_word), 64'h13121110);
    out_ready = 1'b1;
    send(8'h5A, 1'b1);
    chk("dl_valid", 64'(out_valid), 64'd1);
    chk("dl_word",  64'(out_word),  64'h0000005A);
    chk("dl_mask",  64'(out_mask),  64'h1);
    idle();
    chk("dl_drained", 64'(out_valid), 64'd0);

    // Asynchronous reset in the middle of a word
    send(8'hE1, 1'b0);
    send(8'hE2, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_word",  64'(out_word),  64'd0);
    chk("mid_rst_mask",  64'(out_mask),  64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'hD1, 1'b0);
    send(8'hD2, 1'b0);
    send(8'hD3, 1'b0);
    chk("post_rst_no_early", 64'(out_valid), 64'd0);
    send(8'hD4, 1'b0);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_word",  64'(out_word),  64'hD4D3D2D1);
    chk("post_rst_mask",  64'(out_mask),  64'hF);
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lane_packer.md
Name: lane_packer

Overview:
- Serial-to-parallel packer that gathers a byte stream into one packed word of LANES lanes, each DATA_W bits wide, plus a lane-valid mask.
- Sits directly upstream of the concat stage. Its {word, mask} output is the {a, b} operand pair that stage concatenates: a 32-bit packed word and a 4-bit mask, giving a 36-bit result.
- Valid/ready handshake on both sides; holds one output word.

Parameters:
- LANES, 4, number of lanes per output word (>=2).
- DATA_W, 8, bits per lane.
- CNT_W, $clog2(LANES), width of the lane index counter (localparam, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input byte valid.
- in_ready  output  1  packer can accept a byte this cycle.
- in_data  input  DATA_W  input lane value.
- in_last  input  1  closes the current word after this byte, even if fewer than LANES bytes.
- out_valid  output  1  out_word/out_mask hold a complete word.
- out_ready  input  1  downstream accepts the word.
- out_word  output  [LANES-1:0][DATA_W-1:0]  packed lanes; lane 0 is the first byte received.
- out_mask  output  LANES  bit i set iff lane i holds received data.

Behaviour:
- Clock and reset: one clock domain. rst_n is asynchronous and active-low; assertion takes effect immediately, release is synchronous to clk.
- Reset values:
  - out_valid=0, out_word=0, out_mask=0.
  - lane_idx=0, state=FILL.
  - in_ready=1 one cycle after reset release; combinational from state.
- States:
  - FILL: accumulating bytes into an internal accumulator (acc_word, acc_mask).
  - HOLD: a word is presented on out_* and waits for out_ready.
- Input handshake: in_fire = in_valid & in_ready. in_ready = (state==FILL) | out_ready, so a byte can enter in the same cycle a held word is drained.
- On in_fire:
  - acc_word[lane_idx] <= in_data and acc_mask[lane_idx] <= 1.
  - If lane_idx==LANES-1 or in_last: transfer the word to out_word/out_mask (with this byte included), set out_valid=1, clear the accumulator to 0, set lane_idx=0, go to HOLD.
  - Otherwise: lane_idx <= lane_idx+1.
- Output handshake: out_fire = out_valid & out_ready.
  - out_fire with no in_fire that closes a new word: out_valid <= 0, go to FILL. out_word/out_mask keep their last values; the value is don't-care when out_valid=0, and the bench must not check it.
  - out_fire together with an in_fire that closes a word (LANES==1 not allowed; this happens only when a single in_last byte arrives): load the new word, out_valid stays 1, stay in HOLD.
  - out_fire together with a non-closing in_fire: the byte is written to accumulator lane 0, go to FILL.
- Stall: in HOLD with out_ready=0, in_ready=0. out_word/out_mask/out_valid stay stable until accepted (AXI-style; no retraction).
- Unfilled lanes: lanes above the last written lane read 0, with the mask bit 0.
- Latency: the closing byte appears on out_* the cycle after its in_fire.
- Throughput: one byte per cycle, with no bubble at word boundaries when out_ready=1.
- Bounds: lane_idx never exceeds LANES-1, and wraps to 0 only when a word closes. in_last on lane LANES-1 is equivalent to a full word.
- Reset mid-word: partial accumulator contents are discarded and no word is emitted.
- X-safety: in_data is sampled only on in_fire.

Decomposition:
- Shared package lane_pkg:
  - localparams LANES_DEF=4 and DATA_W_DEF=8.
  - typedef lane_t = logic [DATA_W-1:0].
  - typedef word_t = logic [LANES-1:0][DATA_W-1:0].
  - typedef mask_t = logic [LANES-1:0].
  - enum state_e {FILL, HOLD}.
- One sub-module, lane_packer_acc: the accumulator plus lane_idx counter, with write/clear controls. The top-level holds the FSM and the output register.

Test Plan:
- Full word: bytes 0x11,0x22,0x33,0x44 back-to-back, out_ready=1 -> one cycle later out_word=0x44332211, out_mask=4'b1111, out_valid=1 for exactly one cycle.
- Partial word: 0xAA, then 0xBB with in_last=1 -> out_word=0x0000BBAA, out_mask=4'b0011.
- Backpressure: out_ready=0 after a full word 0x01020304 -> in_ready=0; out_* hold stable for 5 cycles; out_ready=1 -> out_fire, and in_ready=1 in that same cycle.
- Streaming: 8 bytes 0x00..0x07 continuous with out_ready=1 -> two words, 0x03020100 then 0x07060504, no in_ready deassertion.
- Simultaneous drain and single-byte last: in HOLD, out_ready=1 with in_data=0x5A and in_last=1 -> next cycle out_valid=1, out_word=0x0000005A, out_mask=4'b0001.
- Reset mid-word: two bytes in, pulse rst_n low asynchronously (mid-cycle) -> out_valid=0 immediately; after release, 4 new bytes 0xD1..0xD4 -> out_word=0xD4D3D2D1, no stale lanes.
